// File: rtl/csm_pkg.sv
// Shared types and defaults for the two-port shared-memory controller.
// Holds no logic of its own.
package csm_pkg;

    localparam int DATABITS_DEF = 8;
    localparam int ERRBITS_DEF  = 2;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_LOCKED  = 2'b01,
        ERR_BAD_REL = 2'b10,
        ERR_PROTO   = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WD     = 3'd2,
        WSTALL = 3'd3,
        CTL    = 3'd4
    } port_state_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_REL   = 2'd1,
        OP_PROTO = 2'd2
    } ctl_op_t;

    // A lock command is malformed if it asks for both operations or claims to be a write.
    function automatic ctl_op_t decode_ctl(input logic rw, input logic hold, input logic rel);
        if ((hold && rel) || rw)
            return OP_PROTO;
        else if (hold)
            return OP_HOLD;
        else
            return OP_REL;
    endfunction

endpackage

// File: rtl/csm_port_fsm.sv
// Per-port command decode, address/op latch, ack/err/read-data registers. Latency: 2 edges accept-to-ack,
// 3 when a B write loses the write port. Backpressure: ack low while busy; enable ignored outside IDLE.
module csm_port_fsm
    import csm_pkg::*;
#(
    parameter bit STALL_EN = 1'b0,
    parameter int DATABITS = DATABITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATABITS-1:0] in_ad,
    input  logic                rw,
    input  logic                enable,
    input  logic                hold,
    input  logic                rel,
    input  logic                locked,
    input  logic                stall,
    input  err_t                ctl_err,
    input  logic [DATABITS-1:0] rd_data,
    output logic                ack,
    output err_t                err,
    output logic [DATABITS-1:0] out_data,
    output port_state_t         state,
    output logic [DATABITS-1:0] addr,
    output ctl_op_t             op
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ack      <= 1'b1;
            err      <= ERR_OK;
            out_data <= '0;
            addr     <= '0;
            op       <= OP_PROTO;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        ack  <= 1'b0;
                        err  <= ERR_OK;
                        addr <= in_ad;
                        if (hold || rel) begin
                            op    <= decode_ctl(rw, hold, rel);
                            state <= CTL;
                        end else begin
                            state <= rw ? WD : RD;
                        end
                    end
                end
                RD: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                    if (locked)
                        err <= ERR_LOCKED;
                    else
                        out_data <= rd_data;
                end
                WD: begin
                    // The data itself is captured by the top; this side only tracks the extra cycle.
                    if (STALL_EN && stall) begin
                        state <= WSTALL;
                    end else begin
                        state <= IDLE;
                        ack   <= 1'b1;
                        if (locked)
                            err <= ERR_LOCKED;
                    end
                end
                WSTALL: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                end
                CTL: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                    err   <= ctl_err;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/csm_ctrl.sv
// Two-port shared-memory controller: lock arbiter, A-priority write mux, memory with two read ports.
// Latency: 2 edges per command (B write +1 on collision). Backpressure: per-port ack low while busy.
module csm_ctrl
    import csm_pkg::*;
#(
    parameter int DATABITS = DATABITS_DEF,
    parameter int ERRBITS  = ERRBITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATABITS-1:0] A_in_AD,
    input  logic                A_rw,
    input  logic                A_enable,
    input  logic                A_hold,
    input  logic                A_release,
    output logic                A_ack,
    output logic [ERRBITS-1:0]  A_err,
    output logic [DATABITS-1:0] A_out_data,
    input  logic [DATABITS-1:0] B_in_AD,
    input  logic                B_rw,
    input  logic                B_enable,
    input  logic                B_hold,
    input  logic                B_release,
    output logic                B_ack,
    output logic [ERRBITS-1:0]  B_err,
    output logic [DATABITS-1:0] B_out_data
);

    port_state_t         a_state, b_state;
    logic [DATABITS-1:0] a_addr, b_addr;
    ctl_op_t             a_op, b_op;
    err_t                a_err_q, b_err_q;
    err_t                a_ctl_err, b_ctl_err;
    owner_t              owner, owner_mid, owner_nxt;
    logic                a_locked, b_locked;
    logic                a_wr, b_wd_ok, b_stall;
    logic                we;
    logic [DATABITS-1:0] waddr, wdat, b_stall_dat;
    logic [DATABITS-1:0] a_rd_data, b_rd_data;
    logic [DATABITS-1:0] mem [2**DATABITS];

    assign a_locked = (owner == OWN_B);
    assign b_locked = (owner == OWN_A);

    // A's lock update is resolved first and B sees its result, so A wins simultaneous holds.
    always_comb begin
        owner_mid = owner;
        a_ctl_err = ERR_OK;
        b_ctl_err = ERR_OK;
        if (a_state == CTL) begin
            case (a_op)
                OP_HOLD: begin
                    if (owner != OWN_B) owner_mid = OWN_A;
                    else                a_ctl_err = ERR_LOCKED;
                end
                OP_REL: begin
                    if (owner == OWN_A) owner_mid = OWN_NONE;
                    else                a_ctl_err = ERR_BAD_REL;
                end
                default: a_ctl_err = ERR_PROTO;
            endcase
        end
        owner_nxt = owner_mid;
        if (b_state == CTL) begin
            case (b_op)
                OP_HOLD: begin
                    if (owner_mid != OWN_A) owner_nxt = OWN_B;
                    else                    b_ctl_err = ERR_LOCKED;
                end
                OP_REL: begin
                    if (owner_mid == OWN_B) owner_nxt = OWN_NONE;
                    else                    b_ctl_err = ERR_BAD_REL;
                end
                default: b_ctl_err = ERR_PROTO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    assign a_wr    = (a_state == WD) && !a_locked;
    assign b_wd_ok = (b_state == WD) && !b_locked;
    assign b_stall = b_wd_ok && a_wr;

    always_comb begin
        we    = 1'b0;
        waddr = a_addr;
        wdat  = A_in_AD;
        if (a_wr) begin
            we = 1'b1;
        end else if (b_state == WSTALL) begin
            we    = 1'b1;
            waddr = b_addr;
            wdat  = b_stall_dat;
        end else if (b_wd_ok) begin
            we    = 1'b1;
            waddr = b_addr;
            wdat  = B_in_AD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            b_stall_dat <= '0;
        else if (b_stall)
            b_stall_dat <= B_in_AD;
    end

    // Contents survive reset, but a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (we && !reset)
            mem[waddr] <= wdat;
    end

    assign a_rd_data = mem[a_addr];
    assign b_rd_data = mem[b_addr];

    csm_port_fsm #(.STALL_EN(1'b0), .DATABITS(DATABITS)) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .in_ad    (A_in_AD),
        .rw       (A_rw),
        .enable   (A_enable),
        .hold     (A_hold),
        .rel      (A_release),
        .locked   (a_locked),
        .stall    (1'b0),
        .ctl_err  (a_ctl_err),
        .rd_data  (a_rd_data),
        .ack      (A_ack),
        .err      (a_err_q),
        .out_data (A_out_data),
        .state    (a_state),
        .addr     (a_addr),
        .op       (a_op)
    );

    csm_port_fsm #(.STALL_EN(1'b1), .DATABITS(DATABITS)) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .in_ad    (B_in_AD),
        .rw       (B_rw),
        .enable   (B_enable),
        .hold     (B_hold),
        .rel      (B_release),
        .locked   (b_locked),
        .stall    (b_stall),
        .ctl_err  (b_ctl_err),
        .rd_data  (b_rd_data),
        .ack      (B_ack),
        .err      (b_err_q),
        .out_data (B_out_data),
        .state    (b_state),
        .addr     (b_addr),
        .op       (b_op)
    );

    assign A_err = a_err_q;
    assign B_err = b_err_q;

endmodule
